// File: rtl/a_compare_pkg.sv
// Shared types and helpers for the a_compare_seq stream checker.
package a_compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index width for a table of the given depth; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/a_compare_seq_if.sv
// Control, expected-table load, data stream and result signals of a_compare_seq.
interface a_compare_seq_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 8
);
    import a_compare_pkg::*;

    localparam int unsigned IDX_W = idx_w(DEPTH);

    logic              exp_wr;
    logic [IDX_W-1:0]  exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [IDX_W:0]    seq_len;
    logic [DATA_W-1:0] comp_mask;
    logic              start;
    logic              abort;
    logic              enable;
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              flag;
    logic              error;
    logic              timeout;
    logic [CNT_W-1:0]  err_count;
    logic [IDX_W-1:0]  first_err_idx;

    modport master (
        output exp_wr, exp_addr, exp_data, seq_len, comp_mask,
        output start, abort, enable, data_valid, data,
        input  busy, flag, error, timeout, err_count, first_err_idx
    );

    modport slave (
        input  exp_wr, exp_addr, exp_data, seq_len, comp_mask,
        input  start, abort, enable, data_valid, data,
        output busy, flag, error, timeout, err_count, first_err_idx
    );

endinterface

// File: rtl/a_compare_exp_mem.sv
// Expected-word table: synchronous write, asynchronous read, deliberately not reset.
module a_compare_exp_mem
    import a_compare_pkg::*;
#(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk_ref,
    input  logic                       wr_en,
    input  logic [idx_w(DEPTH)-1:0]    wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [idx_w(DEPTH)-1:0]    rd_addr,
    output logic [DATA_W-1:0]          rd_data_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk_ref) begin
        mem_q <= mem_d;
    end

    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/a_compare_seq.sv
// Checks a data_valid stream against a masked expected table; reports pass,
// mismatch, timeout, saturating mismatch count and first failing index.
module a_compare_seq
    import a_compare_pkg::*;
#(
    parameter int unsigned DATA_W      = 18,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned STOP_ON_ERR = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           clk_ref,
    input  logic           rst,
    a_compare_seq_if.slave bus
);

    localparam int unsigned     IDX_W   = idx_w(DEPTH);
    localparam int unsigned     LEN_W   = IDX_W + 1;
    localparam int unsigned     TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam bit              STOP    = (STOP_ON_ERR != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    state_e            state_q,     state_d;
    logic              busy_q,      busy_d;
    logic              flag_q,      flag_d;
    logic              error_q,     error_d;
    logic              timeout_q,   timeout_d;
    logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic [IDX_W-1:0]  last_idx_q,  last_idx_d;
    logic [DATA_W-1:0] mask_q,      mask_d;
    logic [IDX_W-1:0]  wr_idx_q,    wr_idx_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic              s1_vld_q,    s1_vld_d;
    logic [DATA_W-1:0] s1_data_q,   s1_data_d;
    logic [IDX_W-1:0]  s1_idx_q,    s1_idx_d;

    logic [DATA_W-1:0] exp_word_c;
    logic [LEN_W-1:0]  len_eff_c;
    logic              mismatch_c;
    logic              timeout_hit_c;
    logic              stop_c;
    logic              accept_c;
    logic              mem_wr_c;

    a_compare_exp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_exp_mem (
        .clk_ref   (clk_ref),
        .wr_en     (mem_wr_c),
        .wr_addr   (bus.exp_addr),
        .wr_data   (bus.exp_data),
        .rd_addr   (s1_idx_q),
        .rd_data_c (exp_word_c)
    );

    // Per-cycle qualifiers; timeout only fires on an idle-enabled cycle, so it
    // is checked ahead of accept in the state update.
    always_comb begin
        len_eff_c     = bus.seq_len;
        if (bus.seq_len == '0 || bus.seq_len > LEN_MAX) begin
            len_eff_c = LEN_MAX;
        end
        mismatch_c    = s1_vld_q && (|((s1_data_q ^ exp_word_c) & mask_q));
        timeout_hit_c = TO_EN && (state_q == ST_RUN) && bus.enable &&
                        !bus.data_valid && (to_cnt_q == TO_LAST);
        stop_c        = STOP && mismatch_c;
        accept_c      = (state_q == ST_RUN) && bus.data_valid && bus.enable &&
                        !timeout_hit_c && !stop_c;
        mem_wr_c      = bus.exp_wr && (state_q == ST_IDLE || state_q == ST_DONE);
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        flag_d      = flag_q;
        error_d     = error_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        last_idx_d  = last_idx_q;
        mask_d      = mask_q;
        wr_idx_d    = wr_idx_q;
        to_cnt_d    = to_cnt_q;
        s1_vld_d    = 1'b0;
        s1_data_d   = s1_data_q;
        s1_idx_d    = s1_idx_q;

        // Stage 2: fold the stage-1 compare into the run statistics.
        if (mismatch_c) begin
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) begin
                first_idx_d = s1_idx_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    flag_d      = 1'b0;
                    error_d     = 1'b0;
                    timeout_d   = 1'b0;
                    err_cnt_d   = '0;
                    first_idx_d = '0;
                    wr_idx_d    = '0;
                    to_cnt_d    = '0;
                    last_idx_d  = IDX_W'(len_eff_c - LEN_W'(1));
                    mask_d      = bus.comp_mask;
                end
            end
            ST_RUN: begin
                if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (stop_c) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else if (accept_c) begin
                    s1_vld_d  = 1'b1;
                    s1_data_d = bus.data;
                    s1_idx_d  = wr_idx_q;
                    wr_idx_d  = wr_idx_q + IDX_W'(1);
                    to_cnt_d  = '0;
                    if (wr_idx_q == last_idx_q) begin
                        state_d = ST_FLUSH;
                    end
                end else if (TO_EN && bus.enable && !bus.data_valid) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                if (err_cnt_q != '0 || mismatch_c) begin
                    error_d = 1'b1;
                end else begin
                    flag_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d     = ST_IDLE;
            flag_d      = 1'b0;
            error_d     = 1'b0;
            timeout_d   = 1'b0;
            err_cnt_d   = '0;
            first_idx_d = '0;
            wr_idx_d    = '0;
            to_cnt_d    = '0;
            s1_vld_d    = 1'b0;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            flag_q      <= 1'b0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            last_idx_q  <= '0;
            mask_q      <= '0;
            wr_idx_q    <= '0;
            to_cnt_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            flag_q      <= flag_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            last_idx_q  <= last_idx_d;
            mask_q      <= mask_d;
            wr_idx_q    <= wr_idx_d;
            to_cnt_q    <= to_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_data_q   <= s1_data_d;
            s1_idx_q    <= s1_idx_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.flag          = flag_q;
    assign bus.error         = error_q;
    assign bus.timeout       = timeout_q;
    assign bus.err_count     = err_cnt_q;
    assign bus.first_err_idx = first_idx_q;

endmodule

// File: tb/tb_a_compare_seq.sv
// Scoreboard bench for a_compare_seq: two instances (continue-on-error and
// stop-on-error) share one directed stimulus stream.
module tb_a_compare_seq;

    localparam int unsigned DATA_W = 18;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int          ALL    = 'h3FFFF;

    typedef struct {
        int flag;
        int err;
        int to;
        int cnt;
        int idx;
        int cyc;
    } exp_t;

    logic        clk_ref = 1'b0;
    logic        rst     = 1'b0;
    logic        exp_wr = 1'b0, start = 1'b0, abort = 1'b0;
    logic        enable = 1'b1, data_valid = 1'b0;
    logic [2:0]  exp_addr = '0;
    logic [3:0]  seq_len = '0;
    logic [17:0] exp_data = '0, comp_mask = '0, data = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    a_compare_seq_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) if0 ();
    a_compare_seq_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) if1 ();

    assign if0.exp_wr = exp_wr;         assign if1.exp_wr = exp_wr;
    assign if0.exp_addr = exp_addr;     assign if1.exp_addr = exp_addr;
    assign if0.exp_data = exp_data;     assign if1.exp_data = exp_data;
    assign if0.seq_len = seq_len;       assign if1.seq_len = seq_len;
    assign if0.comp_mask = comp_mask;   assign if1.comp_mask = comp_mask;
    assign if0.start = start;           assign if1.start = start;
    assign if0.abort = abort;           assign if1.abort = abort;
    assign if0.enable = enable;         assign if1.enable = enable;
    assign if0.data_valid = data_valid; assign if1.data_valid = data_valid;
    assign if0.data = data;             assign if1.data = data;

    a_compare_seq #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(16), .STOP_ON_ERR(0), .CNT_W(CNT_W)
    ) dut0 (
        .clk_ref (clk_ref),
        .rst     (rst),
        .bus     (if0)
    );

    a_compare_seq #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(16), .STOP_ON_ERR(1), .CNT_W(CNT_W)
    ) dut1 (
        .clk_ref (clk_ref),
        .rst     (rst),
        .bus     (if1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int f, input int e, input int t,
                        input int cnt, input int idx, input int c);
        exp_t x;
        x.flag = f; x.err = e; x.to = t; x.cnt = cnt; x.idx = idx; x.cyc = c;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Compare one completed run (busy fell with a verdict) against the queue head.
    task automatic mon(input int d, input int f, input int e, input int t,
                       input int cnt, input int idx);
        exp_t x;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_result actual=completion expected=none (cycle %0d)", d, cyc);
        end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            chk($sformatf("dut%0d_cycle", d),   cyc, x.cyc);
            chk($sformatf("dut%0d_flag", d),    f,   x.flag);
            chk($sformatf("dut%0d_error", d),   e,   x.err);
            chk($sformatf("dut%0d_timeout", d), t,   x.to);
            chk($sformatf("dut%0d_err_cnt", d), cnt, x.cnt);
            chk($sformatf("dut%0d_first", d),   idx, x.idx);
        end
    endtask

    initial begin
        logic b0p = 1'b0;
        logic b1p = 1'b0;
        forever begin
            @(negedge clk_ref);
            if (b0p && !if0.busy && (if0.flag || if0.error))
                mon(0, int'(if0.flag), int'(if0.error), int'(if0.timeout),
                    int'(if0.err_count), int'(if0.first_err_idx));
            if (b1p && !if1.busy && (if1.flag || if1.error))
                mon(1, int'(if1.flag), int'(if1.error), int'(if1.timeout),
                    int'(if1.err_count), int'(if1.first_err_idx));
            b0p = if0.busy;
            b1p = if1.busy;
        end
    end

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic send(input int w);
        data       = 18'(w);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic start_run(input int len, input int mask);
        seq_len   = 4'(len);
        comp_mask = 18'(mask);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push_both_pass();
        push(0, 1, 0, 0, 0, 0, cyc + 1);
        push(1, 1, 0, 0, 0, 0, cyc + 1);
    endtask

    initial begin
        int m;

        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_busy0", int'(if0.busy), 0);          chk("rst_busy1", int'(if1.busy), 0);
        chk("rst_flag0", int'(if0.flag), 0);          chk("rst_flag1", int'(if1.flag), 0);
        chk("rst_error0", int'(if0.error), 0);        chk("rst_error1", int'(if1.error), 0);
        chk("rst_timeout0", int'(if0.timeout), 0);    chk("rst_timeout1", int'(if1.timeout), 0);
        chk("rst_cnt0", int'(if0.err_count), 0);      chk("rst_cnt1", int'(if1.err_count), 0);
        chk("rst_first0", int'(if0.first_err_idx), 0); chk("rst_first1", int'(if1.first_err_idx), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            exp_wr = 1'b1; exp_addr = 3'(i); exp_data = 18'(i + 1);
            tick();
        end
        exp_wr = 1'b0;

        // Clean pass over the full table.
        start_run(8, ALL);
        chk("start_busy0", int'(if0.busy), 1);
        chk("start_busy1", int'(if1.busy), 1);
        for (int i = 0; i < 8; i++) send(i + 1);
        push_both_pass();
        repeat (3) tick();

        // Word 3 corrupted.
        start_run(8, ALL);
        for (int i = 0; i < 8; i++) begin
            send(i == 3 ? 'h3FFFF : i + 1);
            if (i == 3) push(1, 0, 1, 0, 1, 3, cyc + 1);
            if (i == 4) begin
                chk("w3_mid_cnt0", int'(if0.err_count), 1);
                chk("w3_mid_first0", int'(if0.first_err_idx), 3);
                chk("w3_mid_busy1", int'(if1.busy), 0);
            end
        end
        push(0, 0, 1, 0, 1, 3, cyc + 1);
        repeat (3) tick();

        // Words 2 and 5 corrupted; stop-on-error instance ignores the rest.
        start_run(8, ALL);
        for (int i = 0; i < 8; i++) begin
            send(i == 2 ? 'h3FFFF : (i == 5 ? 0 : i + 1));
            if (i == 2) push(1, 0, 1, 0, 1, 2, cyc + 1);
        end
        push(0, 0, 1, 0, 2, 2, cyc + 1);
        repeat (3) tick();
        chk("w25_cnt1_after", int'(if1.err_count), 1);

        // Masked-out bit 0 difference on word 4; table write during RUN dropped.
        start_run(8, 'h3FFF0);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                exp_wr = 1'b1; exp_addr = 3'd7; exp_data = 18'h3FFFF;
            end
            send(i == 4 ? 4 : i + 1);
            exp_wr = 1'b0;
        end
        push_both_pass();
        repeat (3) tick();

        // Short sequence of three words.
        start_run(3, ALL);
        for (int i = 0; i < 3; i++) send(i + 1);
        push_both_pass();
        repeat (3) tick();

        // Timeout: 5 idle cycles, 10 frozen by enable low, then 11 more idle.
        start_run(8, ALL);
        send(1);
        m = cyc;
        push(0, 0, 1, 1, 0, 0, m + 26);
        push(1, 0, 1, 1, 0, 0, m + 26);
        repeat (5) tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (14) tick();

        // start pulse in mid-run must not restart; word 5 corrupted.
        start_run(8, ALL);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) start = 1'b1;
            send(i == 5 ? 0 : i + 1);
            start = 1'b0;
            if (i == 5) push(1, 0, 1, 0, 1, 5, cyc + 1);
        end
        push(0, 0, 1, 0, 1, 5, cyc + 1);
        repeat (3) tick();

        // abort and start together: abort wins.
        start_run(8, ALL);
        send('h3FFFF);
        push(1, 0, 1, 0, 1, 0, cyc + 1);
        send(2);
        chk("pre_abort_cnt0", int'(if0.err_count), 1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_busy0", int'(if0.busy), 0);      chk("abort_busy1", int'(if1.busy), 0);
        chk("abort_cnt0", int'(if0.err_count), 0);  chk("abort_error1", int'(if1.error), 0);
        tick();

        // Asynchronous reset in the middle of a run.
        start_run(8, ALL);
        send(1);
        send('h3FFFF);
        push(1, 0, 1, 0, 1, 1, cyc + 1);
        send(3);
        send(4);
        chk("pre_rst_cnt0", int'(if0.err_count), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy0", int'(if0.busy), 0);
        chk("arst_cnt0", int'(if0.err_count), 0);
        chk("arst_first0", int'(if0.first_err_idx), 0);
        chk("arst_error1", int'(if1.error), 0);
        chk("arst_first1", int'(if1.first_err_idx), 0);
        tick();
        rst = 1'b0;
        tick();

        // Table survives reset; seq_len 0 means the full depth.
        start_run(0, ALL);
        for (int i = 0; i < 8; i++) send(i + 1);
        push_both_pass();
        repeat (4) tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
